// File: rtl/rom_dl_pkg.sv
// rtl/rom_dl_pkg.sv - shared types and constants for the ROM download controller
package rom_dl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } dl_state_e;

  localparam logic [7:0]  DL_INDEX_DEF = 8'd0;
  localparam logic [24:0] ROM_WINDOW   = 25'h001_0000;
  localparam int unsigned BYTES_W      = 17;

endpackage

// File: rtl/dl_edge.sv
// rtl/dl_edge.sv - registered rise/fall detector for an ioctl download level
module dl_edge (
  input  logic clk_sys,
  input  logic reset,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic level_q;

  // The copy keeps tracking during reset so a download already in flight
  // when reset releases is not mistaken for a fresh start.
  always_ff @(posedge clk_sys) begin
    if (reset) level_q <= level;
    else       level_q <= level;
  end

  assign rise = level & ~level_q;
  assign fall = ~level & level_q;

endmodule

// File: rtl/rom_dl_ctrl.sv
// rtl/rom_dl_ctrl.sv - qualifies the ROM download stream and sequences the core reset
module rom_dl_ctrl
  import rom_dl_pkg::*;
#(
  parameter logic [24:0] ROM_BYTES  = ROM_WINDOW,
  parameter logic [7:0]  RESET_HOLD = 8'd255,
  parameter logic [7:0]  DL_INDEX   = DL_INDEX_DEF
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               ioctl_downl,
  input  logic [7:0]         ioctl_index,
  input  logic               ioctl_wr,
  input  logic [24:0]        ioctl_addr,
  input  logic [7:0]         ioctl_dout,
  input  logic               user_reset,
  output logic [15:0]        dn_addr,
  output logic [7:0]         dn_data,
  output logic               dn_wr,
  output logic               rom_loaded,
  output logic               core_reset,
  output logic [BYTES_W-1:0] dl_bytes,
  output logic [15:0]        dl_sum,
  output logic               dl_error
);

  dl_state_e          state, state_nxt;
  logic [7:0]         hold_cnt;
  logic               dl_rise, dl_fall;
  logic               idx_ok, qw, in_win, start, loading, acc, bad_wr, finish;
  logic [BYTES_W-1:0] bytes_base, bytes_nxt;
  logic [15:0]        sum_nxt;
  logic               err_nxt;

  dl_edge u_dl_edge (
    .clk_sys (clk_sys),
    .reset   (reset),
    .level   (ioctl_downl),
    .rise    (dl_rise),
    .fall    (dl_fall)
  );

  assign idx_ok  = (ioctl_index == DL_INDEX);
  assign qw      = ioctl_downl & ioctl_wr & idx_ok;
  assign in_win  = (ioctl_addr < ROM_BYTES);
  assign start   = dl_rise & idx_ok & ((state == IDLE) | (state == RUN));
  assign loading = (state == LOAD) | start;
  assign acc     = loading & qw & in_win;
  assign bad_wr  = loading & qw & ~in_win;
  assign finish  = (state == LOAD) & dl_fall;

  // A new download clears the tallies in the same cycle it may count a byte.
  assign bytes_base = start ? '0 : dl_bytes;
  assign bytes_nxt  = (acc && bytes_base != '1) ? bytes_base + 1'b1 : bytes_base;
  assign sum_nxt    = (start ? 16'h0 : dl_sum) + (acc ? {8'h00, ioctl_dout} : 16'h0);
  assign err_nxt    = (start ? 1'b0 : dl_error) | bad_wr;

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: if (dl_fall) state_nxt = (bytes_nxt == '0) ? IDLE : HOLD;
      HOLD: if (hold_cnt == 8'd0) state_nxt = RUN;
      RUN:  if (start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    core_reset = 1'b1;
    case (state)
      IDLE:    core_reset = rom_loaded ? user_reset : 1'b1;
      LOAD:    core_reset = 1'b1;
      HOLD:    core_reset = 1'b1;
      RUN:     core_reset = user_reset;
      default: core_reset = 1'b1;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dn_wr      <= 1'b0;
      dn_addr    <= 16'h0;
      dn_data    <= 8'h0;
      rom_loaded <= 1'b0;
      dl_bytes   <= '0;
      dl_sum     <= 16'h0;
      dl_error   <= 1'b0;
      hold_cnt   <= 8'd0;
    end else begin
      dn_wr <= acc;
      if (acc) begin
        dn_addr <= ioctl_addr[15:0];
        dn_data <= ioctl_dout;
      end
      if (loading) begin
        dl_bytes <= bytes_nxt;
        dl_sum   <= sum_nxt;
        dl_error <= err_nxt | (finish & (bytes_nxt == '0));
      end
      if (finish && bytes_nxt != '0) begin
        rom_loaded <= 1'b1;
        hold_cnt   <= RESET_HOLD;
      end else if (state == HOLD && hold_cnt != 8'd0) begin
        hold_cnt <= hold_cnt - 8'd1;
      end
    end
  end

endmodule
